// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-outstanding imem handshake and a one-entry skid buffer.
// Optional build macro FETCH_DELAY_SLOT_EN: redirects keep the in-flight sequential instruction (branch delay slot).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic        accept_s;
  logic        outstanding_s;
  logic [31:0] redirect_tgt_s;
  logic [31:0] pc_next_s;

  assign accept_s       = (state_q == S_REQ) && !stall && imem_ready;
  // A request is in flight past this cycle if it was just accepted or its response has not arrived yet.
  assign outstanding_s  = accept_s || ((state_q == S_WAIT) && !imem_rvalid);
  assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_DELAY_SLOT_EN
  logic redir_pend_q, redir_pend_d;
  // After a redirect the pc already holds the target, so the delay-slot delivery must not advance it.
  assign pc_next_s = redir_pend_q ? pc_q : (pc_q + 32'd4);
`else
  assign pc_next_s = pc_q + 32'd4;
`endif

  // Next-state and datapath update for the fetch FSM, skid buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if_id_pc_d   = if_id_pc_q;
    if (stall) begin
      if_id_valid_d = if_id_valid_q;
      if_id_instr_d = if_id_instr_q;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0000_0000;
    end
`ifdef FETCH_DELAY_SLOT_EN
    redir_pend_d = redir_pend_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (accept_s) begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (!imem_rvalid) begin
          state_d = S_WAIT;
        end else if (kill_q) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else begin
          pc_d = pc_next_s;
`ifdef FETCH_DELAY_SLOT_EN
          redir_pend_d = 1'b0;
`endif
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = fetch_pc_q;
            state_d       = S_REQ;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = fetch_pc_q;
            state_d      = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!stall) begin
          if_id_valid_d = skid_valid_q;
          if_id_instr_d = skid_instr_q;
          if_id_pc_d    = skid_pc_q;
          skid_valid_d  = 1'b0;
          state_d       = S_REQ;
        end else begin
          state_d = S_FULL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides stall and any same-cycle delivery.
    if (redirect_valid) begin
      pc_d = redirect_tgt_s;
`ifdef FETCH_DELAY_SLOT_EN
      redir_pend_d = outstanding_s;
`else
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0000_0000;
      skid_valid_d  = 1'b0;
      kill_d        = outstanding_s;
      state_d       = outstanding_s ? S_WAIT : S_REQ;
`endif
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= 32'h0000_0000;
      skid_pc_q     <= 32'h0000_0000;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0000_0000;
      if_id_pc_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

`ifdef FETCH_DELAY_SLOT_EN
  // Pending-redirect flag for the delay-slot build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_pend_q <= 1'b0;
    end else begin
      redir_pend_q <= redir_pend_d;
    end
  end
`endif

  assign imem_req    = (state_q == S_REQ) && !stall;
  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign opcode      = if_id_instr_q[31:26];
  assign funct       = if_id_instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stall/skid, ready backpressure, redirect, reset and PC wrap.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        if_id_valid, if_id_valid2;
  logic [31:0] if_id_instr, if_id_instr2;
  logic [31:0] if_id_pc, if_id_pc2;
  logic [5:0]  opcode, opcode2;
  logic [5:0]  funct, funct2;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .opcode(opcode), .funct(funct)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid2), .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2),
    .opcode(opcode2), .funct(funct2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #12;
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", if_id_valid, 32'd0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_opfn", {opcode, funct}, 32'h0);
    rst_n = 1'b1;

    // First fetch at address 0
    tick();
    check("req1_req", imem_req, 32'd1);
    check("req1_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    tick();
    check("wait1_req", imem_req, 32'd0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    check("f1_valid", if_id_valid, 32'd1);
    check("f1_pc", if_id_pc, 32'h0);
    check("f1_opcode", opcode, 32'h08);
    check("f1_next_addr", imem_addr, 32'h4);
    check("f1_req", imem_req, 32'd1);

    // Stall during delivery fills the skid buffer
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    check("bub_valid", if_id_valid, 32'd0);
    check("bub_instr", if_id_instr, 32'h0);
    check("bub_pc", if_id_pc, 32'h0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0109_5020; stall = 1'b1;
    tick();
    check("skid_hold_valid", if_id_valid, 32'd0);
    check("skid_req", imem_req, 32'd0);
    check("skid_addr", imem_addr, 32'h8);
    imem_rvalid = 1'b0;
    tick();
    check("full_hold_valid", if_id_valid, 32'd0);
    stall = 1'b0;
    #1;
    check("full_req", imem_req, 32'd0);
    tick();
    check("unskid_instr", if_id_instr, 32'h0109_5020);
    check("unskid_funct", funct, 32'h20);
    check("unskid_pc", if_id_pc, 32'h4);
    check("unskid_valid", if_id_valid, 32'd1);
    check("unskid_addr", imem_addr, 32'h8);

    // Stall in REQ suppresses the request and holds IF/ID
    stall = 1'b1; imem_ready = 1'b1;
    #1;
    check("stall_req", imem_req, 32'd0);
    tick();
    check("stall_hold_valid", if_id_valid, 32'd1);
    check("stall_hold_instr", if_id_instr, 32'h0109_5020);

    // imem_ready low for three cycles
    stall = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_req", imem_req, 32'd1);
      check("bp_addr", imem_addr, 32'h8);
      check("bp_valid", if_id_valid, 32'd0);
    end
    imem_ready = 1'b1;
    tick();

    // Redirect while fetch of address 8 is outstanding
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("redir_req", imem_req, 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0008;
    tick();
`ifdef FETCH_DELAY_SLOT_EN
    check("ds_valid", if_id_valid, 32'd1);
    check("ds_instr", if_id_instr, 32'h8C22_0008);
    check("ds_pc", if_id_pc, 32'h8);
`else
    check("kill_valid", if_id_valid, 32'd0);
    check("kill_instr", if_id_instr, 32'h0);
    check("kill_pc", if_id_pc, 32'h4);
`endif
    check("tgt_req", imem_req, 32'd1);
    check("tgt_addr", imem_addr, 32'h100);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1234;
    tick();
    check("tgt_valid", if_id_valid, 32'd1);
    check("tgt_pc", if_id_pc, 32'h100);
    check("tgt_opcode", opcode, 32'h0F);
    check("tgt_next_addr", imem_addr, 32'h104);

    // Reset mid-transaction, stale rvalid afterwards
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_valid", if_id_valid, 32'd0);
    check("mrst_req", imem_req, 32'd0);
    check("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    rst_n = 1'b1;
    tick();
    check("stale_valid", if_id_valid, 32'd0);
    check("stale_instr", if_id_instr, 32'h0);
    check("stale_req", imem_req, 32'd1);
    check("stale_addr", imem_addr, 32'h0);
    check("wrap_req_addr", imem_addr2, 32'hFFFF_FFFC);

    // Both instances fetch once; the wrap instance rolls over to 0
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_rvalid = 1'b0;
    check("post_rst_addr", imem_addr, 32'h4);
    check("wrap_next_addr", imem_addr2, 32'h0);
    check("wrap_pc", if_id_pc2, 32'hFFFF_FFFC);
    check("wrap_valid", if_id_valid2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
